// File: rtl/reg_writeback_arbiter.sv
// Register-file write-side arbiter: merges single-cycle ALU results with
// buffered variable-latency memory results onto one registered write port.
module reg_writeback_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        alu_valid,
  input  logic [ADDR_WIDTH-1:0]       alu_dest,
  input  logic [DATA_WIDTH-1:0]       alu_data,
  output logic                        alu_stall,
  input  logic                        mem_valid,
  output logic                        mem_ready,
  input  logic [ADDR_WIDTH-1:0]       mem_dest,
  input  logic [DATA_WIDTH-1:0]       mem_data,
  output logic                        RegWrite,
  output logic [ADDR_WIDTH-1:0]       write_address,
  output logic [DATA_WIDTH-1:0]       write_data,
  output logic [31:0]                 pending_mask,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [ADDR_WIDTH-1:0] dest_mem_r [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_r [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic [SW-1:0]         starve_r;
  logic                  we_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;

  logic                  alu_stall_s;
  logic                  mem_ready_s;
  logic                  alu_wr_s;
  logic                  deq_s;
  logic                  enq_s;
  logic [PW-1:0]         off_s;
  logic [31:0]           mask_s;

  // Port arbitration: an ALU write always owns the port; the FIFO head fills idle slots.
  always_comb begin
    alu_stall_s = (starve_r >= SW'(STARVE_LIMIT));
    mem_ready_s = (count_r < CW'(FIFO_DEPTH));
    alu_wr_s    = alu_valid & ~alu_stall_s & (alu_dest != {ADDR_WIDTH{1'b0}});
    deq_s       = (count_r != {CW{1'b0}}) & ~alu_wr_s;
    enq_s       = mem_valid & mem_ready_s & (mem_dest != {ADDR_WIDTH{1'b0}});
  end

  // Pending-destination mask: an entry is live when its distance from the head is below the count.
  always_comb begin
    mask_s = 32'd0;
    off_s  = {PW{1'b0}};
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      off_s = PW'(i) - rd_ptr_r;
      if ({1'b0, off_s} < count_r) begin
        mask_s = mask_s | (32'd1 << dest_mem_r[i]);
      end else begin
        mask_s = mask_s;
      end
    end
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        dest_mem_r[i] <= {ADDR_WIDTH{1'b0}};
        data_mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (enq_s) begin
        dest_mem_r[wr_ptr_r] <= mem_dest;
        data_mem_r[wr_ptr_r] <= mem_data;
        wr_ptr_r             <= wr_ptr_r + PW'(1'b1);
      end
      if (deq_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      end
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Starvation counter: counts blocked head cycles, saturating at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_r <= {SW{1'b0}};
    end else if ((count_r == {CW{1'b0}}) || deq_s) begin
      starve_r <= {SW{1'b0}};
    end else if (starve_r < SW'(STARVE_LIMIT)) begin
      starve_r <= starve_r + SW'(1'b1);
    end else begin
      starve_r <= starve_r;
    end
  end

  // Registered write port; address and data hold through idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r    <= 1'b0;
      addr_r  <= {ADDR_WIDTH{1'b0}};
      wdata_r <= {DATA_WIDTH{1'b0}};
    end else if (alu_wr_s) begin
      we_r    <= 1'b1;
      addr_r  <= alu_dest;
      wdata_r <= alu_data;
    end else if (deq_s) begin
      we_r    <= 1'b1;
      addr_r  <= dest_mem_r[rd_ptr_r];
      wdata_r <= data_mem_r[rd_ptr_r];
    end else begin
      we_r    <= 1'b0;
    end
  end

  assign alu_stall     = alu_stall_s;
  assign mem_ready     = mem_ready_s;
  assign RegWrite      = we_r;
  assign write_address = addr_r;
  assign write_data    = wdata_r;
  assign pending_mask  = mask_s;
  assign fifo_count    = count_r;

endmodule
